tc_timer: RTL and testbench
===========================

# tc_timer

Memory-mapped programmable countdown timer on the CPU's system bus, directly downstream of the pipelined datapath. Consumes the M-stage store port (address, store data, write enable) and returns read data for M-stage loads. Raises an interrupt request that feeds one bit of the datapath's 6-bit hardware interrupt input. Supports one-shot and auto-reload modes through a small state machine.

## Interface
- `BASE`, default `32'h0000_7F00`: base address; the block decodes the 16-byte window `BASE[31:4]`.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `addr` in 32: bus address (datapath M-stage ALU result).
- `we` in 1: bus write enable, already gated by the datapath for exceptions.
- `wdata` in 32: store data.
- `rdata` out 32: read data, combinational from current register state.
- `irq` out 1: interrupt request to one `HW` bit.

## Operation
- The block is selected when `addr[31:4] == BASE[31:4]`. The register index is `addr[3:2]`:
  - 0: CTRL
  - 1: PRESET
  - 2: COUNT, read-only
  - 3: reserved; reads 0, writes ignored
- Unselected or `we=0` cycles change no registers. `rdata` is 0 when the block is not selected.
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00.
  - [3] IM: interrupt mask, 1 = enabled.
  - [31:4] read as 0.
- PRESET: 32-bit reload value. COUNT: 32-bit down-counter. CPU writes to COUNT are ignored.
- State machine, with states IDLE, LOAD, CNT, INT:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if EN=0, go to IDLE with COUNT frozen. Else if COUNT==0, go to INT. Else COUNT <= COUNT-1.
  - INT: set the interrupt flag (IRQF) and go to IDLE. In one-shot mode, also clear CTRL.EN.
- `irq` = IRQF & CTRL.IM.
- One-shot: IRQF holds until a CPU write to CTRL or PRESET.
- Auto-reload: IRQF clears on the edge after it is set, giving a one-cycle pulse. EN stays 1, so the timer reloads automatically.
- Simultaneous events:
  - A CPU write to CTRL in the same cycle as INT wins for all CTRL bits, including EN.
  - IRQF set by INT wins over the write-clear in the same cycle.
  - A PRESET write during CNT does not change the current count; the new value takes effect at the next LOAD.
- A PRESET of 0 is legal: LOAD, then CNT sees 0 and goes to INT.
- COUNT wraps never: it decrements only while nonzero.

## Timing
- Reset (asynchronous, `reset`=0): state = IDLE; CTRL, PRESET, COUNT, and IRQF = 0. Outputs: `irq`=0; `rdata`=0 for CTRL/PRESET/COUNT reads.
- Reset mid-count aborts immediately, with no interrupt.
- Register writes take effect at the edge on which `we`=1.
- Reads are zero-latency combinational, so the datapath registers them into W.
- Let the write setting EN=1 with PRESET=N be edge 0:
  - Edge 1: LOAD.
  - Edge 2: COUNT=N, state CNT.
  - After edge N+2: COUNT=0.
  - Edge N+3: INT.
  - Edge N+4: IRQF=1, state IDLE.
  - `irq` is high from edge N+4, provided IM=1.
- Auto-reload period is N+4 cycles, counted from LOAD entry to the next LOAD entry.
- Clearing EN during CNT stops the count at the next edge.

## Configuration
- `TC_AUTORELOAD_EN` defined: MODE=01 behaves as auto-reload, as described above.
- `TC_AUTORELOAD_EN` undefined: all MODE values behave as one-shot. MODE bits remain readable and writable; the auto-reload logic is not synthesised.

## Test plan
- Reset, then read all three registers. Required: every read returns 0 and `irq`=0. Assert `reset`=0 during CNT with COUNT=5 and check COUNT=0 and state IDLE immediately.
- PRESET=3, CTRL=0x9 (EN, one-shot, IM). Required: COUNT reads 3,2,1,0; `irq` rises 7 edges after the CTRL write. CTRL then reads 0x8, and `irq` holds until a write of CTRL=0x8 clears it.
- PRESET=2, CTRL=0xB (auto-reload), with the macro defined. Required: `irq` is a one-cycle pulse every 6 cycles, and EN stays 1. Without the macro, the same stimulus gives one-shot behaviour.
- CTRL=0x1 (IM=0) with PRESET=1. Required: the timer completes and IRQF is set, but `irq` stays 0. A later write of CTRL=0x8 clears IRQF, so `irq` stays low.
- During CNT with COUNT=10, write PRESET=4 and then write to COUNT. Required: the count continues 9,8,… unchanged, and the next reload uses 4. Write CTRL=0 mid-count: COUNT freezes.
- Access `BASE+0xC` and an address outside the window. Required: reads return 0 and writes have no effect.

Source files
------------

// File: rtl/tc_timer_if.sv
// tc_timer_if: CPU M-stage system bus port carrying address, store data,
// write enable and the combinational load data returned by the slave.
interface tc_timer_if;
    localparam int unsigned DW = 32;

    logic [DW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer (CTRL/PRESET/COUNT) with masked IRQ.
// Optional feature macro TC_AUTORELOAD_EN: MODE=01 selects auto-reload, else every MODE is one-shot.
module tc_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic      clk,
    input  logic      reset,
    tc_timer_if.slave bus,
    output logic      irq
);
    localparam int unsigned DW     = 32;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned CTRL_W = 4;

    localparam logic [IDX_W-1:0] REG_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] REG_PRESET = IDX_W'(1);
    localparam logic [IDX_W-1:0] REG_COUNT  = IDX_W'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic             r_irqf;
    logic [DW-1:0]    r_preset;
    logic [DW-1:0]    r_count;
    logic [DW-1:0]    w_count_nxt;
    logic             w_int_set;
    logic             w_en_clr;
    logic             w_auto;
    logic             w_sel;
    logic [IDX_W-1:0] w_idx;
    logic             w_wr_ctrl;
    logic             w_wr_preset;
    logic             w_unused_addr;

    // Address decode over the 16-byte window; byte offset bits are ignored.
    assign w_sel         = (bus.addr[31:4] == BASE[31:4]);
    assign w_idx         = bus.addr[3:2];
    assign w_wr_ctrl     = w_sel && bus.we && (w_idx == REG_CTRL);
    assign w_wr_preset   = w_sel && bus.we && (w_idx == REG_PRESET);
    assign w_unused_addr = ^bus.addr[1:0];

`ifdef TC_AUTORELOAD_EN
    assign w_auto = (r_mode == 2'b01);
`else
    assign w_auto = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, counter update and interrupt events.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_int_set   = 1'b0;
        w_en_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_count_nxt = r_preset;
                w_state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!r_en)                w_state_nxt = S_IDLE;
                else if (r_count == '0)   w_state_nxt = S_INT;
                else                      w_count_nxt = r_count - DW'(1);
            end
            S_INT: begin
                w_int_set   = 1'b1;
                w_en_clr    = !w_auto;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // CPU writes win over the one-shot EN clear; an INT set wins over the write clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_en     <= 1'b0;
            r_mode   <= 2'b00;
            r_im     <= 1'b0;
            r_irqf   <= 1'b0;
            r_preset <= '0;
            r_count  <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_wr_ctrl) begin
                r_en   <= bus.wdata[0];
                r_mode <= bus.wdata[2:1];
                r_im   <= bus.wdata[3];
            end else if (w_en_clr) begin
                r_en <= 1'b0;
            end
            if (w_wr_preset) r_preset <= bus.wdata;
            if (w_int_set)                       r_irqf <= 1'b1;
            else if (w_wr_ctrl || w_wr_preset)   r_irqf <= 1'b0;
            else if (w_auto)                     r_irqf <= 1'b0;
        end
    end

    always_comb begin
        bus.rdata = '0;
        if (w_sel) begin
            case (w_idx)
                REG_CTRL:   bus.rdata = {{(DW-CTRL_W){1'b0}}, r_im, r_mode, r_en};
                REG_PRESET: bus.rdata = r_preset;
                REG_COUNT:  bus.rdata = r_count;
                default:    bus.rdata = '0;
            endcase
        end
    end

    assign irq = r_irqf & r_im;
endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed vector table, multi-cycle corner sequences and a
// randomized run against a behavioural reference model of the timer.
module tb_tc_timer;
    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'd4;
    localparam logic [31:0] A_CNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSV  = BASE + 32'd12;
    localparam logic [31:0] A_OUT  = BASE + 32'd16;
    localparam logic [31:0] A_FAR  = 32'h1234_7F04;
`ifdef TC_AUTORELOAD_EN
    localparam bit USE_AUTO = 1'b1;
`else
    localparam bit USE_AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic irq;
    int   n_cmp = 0;
    int   n_err = 0;

    tc_timer_if bus_if();
    tc_timer #(.BASE(BASE)) dut (.clk(clk), .reset(reset), .bus(bus_if), .irq(irq));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_irq;
        logic        exp_irq;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic cr, input logic [31:0] er,
                                input logic ci, input logic ei);
        vec_t v;
        v.addr = a; v.we = w; v.wdata = d;
        v.chk_rd = cr; v.exp_rd = er; v.chk_irq = ci; v.exp_irq = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.we    = w;
        bus_if.wdata = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        drive(a, 1'b1, d);
        tick();
        bus_if.we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(A_OUT, 1'b0, 32'd0);
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference model: spec-level registers and timer phase.
    typedef enum int {PH_IDLE, PH_LOAD, PH_RUN, PH_FIRE} phase_t;
    phase_t      m_ph;
    bit          m_en, m_im, m_irqf;
    bit [1:0]    m_mode;
    bit [31:0]   m_preset, m_count;

    function automatic void m_reset();
        m_ph = PH_IDLE; m_en = 0; m_im = 0; m_irqf = 0; m_mode = 0;
        m_preset = 0; m_count = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'd0;
        case (a[3:2])
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_step(input logic [31:0] a, input logic w, input logic [31:0] d);
        bit     sel = (a[31:4] == BASE[31:4]);
        bit     wc  = sel && w && (a[3:2] == 2'd0);
        bit     wp  = sel && w && (a[3:2] == 2'd1);
        bit     ar  = USE_AUTO && (m_mode == 2'b01);
        bit     fire = 0;
        phase_t ph  = m_ph;
        case (m_ph)
            PH_IDLE: if (m_en) ph = PH_LOAD;
            PH_LOAD: begin m_count = m_preset; ph = PH_RUN; end
            PH_RUN: begin
                if (!m_en) ph = PH_IDLE;
                else if (m_count == 0) ph = PH_FIRE;
                else m_count = m_count - 1;
            end
            default: begin fire = 1; ph = PH_IDLE; end
        endcase
        m_ph = ph;
        if (fire) m_irqf = 1;
        else if (wc || wp || ar) m_irqf = 0;
        if (fire && !ar) m_en = 0;
        if (wc) begin m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; end
        if (wp) m_preset = d;
    endfunction

    logic [31:0] rsel[6];

    initial begin
        reset = 1'b0;
        bus_if.addr = '0; bus_if.we = 1'b0; bus_if.wdata = '0;
        @(negedge clk);

        // Reset reads
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_PRE,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_RSV,  0, 0, 1, 32'd0, 1, 0));
        // One-shot PRESET=3, CTRL=0x9
        vt.push_back(mk(A_PRE,  1, 3, 0, 32'd0, 0, 0));
        vt.push_back(mk(A_CTRL, 1, 9, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd3, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd2, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd1, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd9, 1, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd8, 1, 1));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 1));
        vt.push_back(mk(A_CTRL, 1, 8, 1, 32'd8, 1, 1));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd8, 1, 0));
        // IM=0: PRESET=1, CTRL=0x1
        vt.push_back(mk(A_PRE,  1, 1, 1, 32'd3, 1, 0));
        vt.push_back(mk(A_CTRL, 1, 1, 1, 32'd8, 1, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd1, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd1, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd1, 1, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CTRL, 1, 8, 1, 32'd0, 1, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd8, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));
        // Reserved and out-of-window accesses
        vt.push_back(mk(A_RSV,  1, 32'hFFFF_FFFF, 1, 32'd0, 0, 0));
        vt.push_back(mk(A_RSV,  0, 0, 1, 32'd0, 0, 0));
        vt.push_back(mk(A_OUT,  1, 32'h0000_0001, 1, 32'd0, 0, 0));
        vt.push_back(mk(A_FAR,  1, 32'd7, 1, 32'd0, 0, 0));
        vt.push_back(mk(A_CTRL, 0, 0, 1, 32'd8, 1, 0));
        vt.push_back(mk(A_PRE,  0, 0, 1, 32'd1, 1, 0));
        vt.push_back(mk(A_CNT,  0, 0, 1, 32'd0, 1, 0));

        do_reset();
        foreach (vt[i]) begin
            drive(vt[i].addr, vt[i].we, vt[i].wdata);
            if (vt[i].chk_rd)  chk($sformatf("vec%0d_rdata", i), bus_if.rdata, vt[i].exp_rd);
            if (vt[i].chk_irq) chk($sformatf("vec%0d_irq", i), 32'(irq), 32'(vt[i].exp_irq));
            tick();
        end
        bus_if.we = 1'b0;

        // Auto-reload (or one-shot without the macro): PRESET=2, CTRL=0xB
        do_reset();
        wr(A_PRE, 32'd2);
        wr(A_CTRL, 32'hB);
        for (int k = 0; k < 20; k++) begin
            logic        e_irq;
            logic [31:0] e_ctrl;
            if (USE_AUTO) begin
                e_irq  = (k >= 6) && ((k - 6) % 6 == 0);
                e_ctrl = 32'hB;
            end else begin
                e_irq  = (k >= 6);
                e_ctrl = (k >= 6) ? 32'hA : 32'hB;
            end
            drive(A_CTRL, 1'b0, 32'd0);
            chk($sformatf("reload_irq_k%0d", k), 32'(irq), 32'(e_irq));
            chk($sformatf("reload_ctrl_k%0d", k), bus_if.rdata, e_ctrl);
            tick();
        end
        wr(A_CTRL, 32'd0);

        // Asynchronous reset while counting with COUNT=5
        do_reset();
        wr(A_PRE, 32'd5);
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        drive(A_CNT, 1'b0, 32'd0);
        chk("rst_count_before", bus_if.rdata, 32'd5);
        reset = 1'b0;
        #1;
        chk("rst_count_async", bus_if.rdata, 32'd0);
        chk("rst_irq_async", 32'(irq), 32'd0);
        drive(A_CTRL, 1'b0, 32'd0);
        chk("rst_ctrl_async", bus_if.rdata, 32'd0);
        drive(A_PRE, 1'b0, 32'd0);
        chk("rst_preset_async", bus_if.rdata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        drive(A_CNT, 1'b0, 32'd0);
        chk("rst_count_after", bus_if.rdata, 32'd0);
        chk("rst_irq_after", 32'(irq), 32'd0);

        // PRESET and COUNT writes during CNT, then a freeze by clearing EN
        do_reset();
        wr(A_PRE, 32'd10);
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        drive(A_CNT, 1'b0, 32'd0);
        chk("midcnt_count10", bus_if.rdata, 32'd10);
        wr(A_PRE, 32'd4);
        drive(A_CNT, 1'b0, 32'd0);
        chk("midcnt_count9", bus_if.rdata, 32'd9);
        wr(A_CNT, 32'h55);
        drive(A_CNT, 1'b0, 32'd0);
        chk("midcnt_count8", bus_if.rdata, 32'd8);
        tick();
        chk("midcnt_count7", bus_if.rdata, 32'd7);
        begin
            bit got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) begin
                drive(A_CTRL, 1'b0, 32'd0);
                if (irq) got = 1'b1;
                else     tick();
            end
            chk("midcnt_irq_seen", 32'(got), 32'd1);
            chk("midcnt_ctrl_after", bus_if.rdata, 32'h8);
        end
        wr(A_CTRL, 32'h9);
        tick();
        tick();
        drive(A_CNT, 1'b0, 32'd0);
        chk("reload_new_preset", bus_if.rdata, 32'd4);
        wr(A_CTRL, 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(A_CNT, 1'b0, 32'd0);
            chk($sformatf("freeze_count_%0d", k), bus_if.rdata, 32'd3);
            tick();
        end

        // Randomized traffic against the reference model
        rsel[0] = A_CTRL; rsel[1] = A_PRE; rsel[2] = A_CNT;
        rsel[3] = A_RSV;  rsel[4] = A_OUT; rsel[5] = A_FAR;
        do_reset();
        m_reset();
        for (int i = 0; i < 4000; i++) begin
            logic [31:0] a;
            logic        w;
            logic [31:0] d;
            a = rsel[$urandom_range(0, 5)];
            w = ($urandom_range(0, 99) < 10);
            d = $urandom();
            if (a == A_PRE) d = 32'($urandom_range(0, 6));
            if (a == A_CTRL && $urandom_range(0, 2) != 0) d[0] = 1'b1;
            drive(a, w, d);
            chk($sformatf("rand%0d_rdata", i), bus_if.rdata, m_read(a));
            chk($sformatf("rand%0d_irq", i), 32'(irq), 32'(m_irqf & m_im));
            m_step(a, w, d);
            tick();
        end
        bus_if.we = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
